// File: rtl/power_gate_seq_multi.sv
// Multi-rail power-gate sequencer: ramps thermometer-coded rail enables up and
// down with per-step dwell times, and controls domain isolation around ON.
module power_gate_seq_multi #(
  parameter  int N_STEPS = 8,
  parameter  int CNT_W   = 8,
  localparam int LW      = $clog2(N_STEPS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     power,
  input  logic                     external_pg,
  input  logic [N_STEPS*CNT_W-1:0] hold_time,
  input  logic                     wu_bypass_mux,
  input  logic                     isolate_byp,
  output logic [N_STEPS-1:0]       rail,
  output logic [LW-1:0]            level,
  output logic                     isolate,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_UP   = 3'd1,
    S_ON   = 3'd2,
    S_ISO  = 3'd3,
    S_DOWN = 3'd4
  } state_t;

  state_t             state;
  logic [LW-1:0]      lvl;
  logic [CNT_W-1:0]   cnt;
  logic [N_STEPS-1:0] rail_q;
  logic               iso_q;

  logic               req;
  logic [LW-1:0]      idx;
  logic [CNT_W-1:0]   dwell;
  logic [CNT_W-1:0]   last;
  logic               hit;

  function automatic logic [N_STEPS-1:0] therm(input logic [LW-1:0] l);
    logic [N_STEPS-1:0] t;
    t = '0;
    for (int k = 0; k < N_STEPS; k++) t[k] = (LW'(k) < l);
    return t;
  endfunction

  assign req = power | external_pg;

  // Dwell of the step currently being entered or left (step L-1); 0 acts as 1.
  always_comb begin
    idx   = (lvl == '0) ? '0 : lvl - LW'(1);
    dwell = '0;
    for (int k = 0; k < N_STEPS; k++) begin
      if (idx == LW'(k)) dwell = hold_time[k*CNT_W +: CNT_W];
    end
    last = (dwell == '0) ? '0 : dwell - CNT_W'(1);
    hit  = (cnt == last);
  end

  // Isolation register defaults high and is cleared only on entry to ON.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_OFF;
      lvl    <= '0;
      cnt    <= '0;
      rail_q <= '0;
      iso_q  <= 1'b1;
    end else begin
      iso_q <= 1'b1;
      case (state)
        S_OFF: begin
          cnt <= '0;
          if (req) begin
            state  <= S_UP;
            lvl    <= LW'(1);
            rail_q <= therm(LW'(1));
          end else begin
            lvl    <= '0;
            rail_q <= '0;
          end
        end
        S_UP: begin
          if (!req) begin
            state <= S_DOWN;
            cnt   <= '0;
          end else if (hit) begin
            cnt <= '0;
            if (lvl == LW'(N_STEPS)) begin
              state <= S_ON;
              iso_q <= 1'b0;
            end else begin
              lvl    <= lvl + LW'(1);
              rail_q <= therm(lvl + LW'(1));
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ON: begin
          if (!req) state <= S_ISO;
          else      iso_q <= 1'b0;
        end
        S_ISO: begin
          if (req) begin
            state <= S_ON;
            iso_q <= 1'b0;
          end else begin
            state <= S_DOWN;
            cnt   <= '0;
          end
        end
        S_DOWN: begin
          if (req) begin
            state <= S_UP;
            cnt   <= '0;
          end else if (hit) begin
            lvl    <= lvl - LW'(1);
            rail_q <= therm(lvl - LW'(1));
            cnt    <= '0;
            if (lvl == LW'(1)) state <= S_OFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= S_OFF;
          lvl    <= '0;
          cnt    <= '0;
          rail_q <= '0;
        end
      endcase
    end
  end

  assign rail    = rail_q;
  assign level   = lvl;
  assign isolate = wu_bypass_mux ? isolate_byp : iso_q;
  assign busy    = (state == S_UP) || (state == S_ISO) || (state == S_DOWN);
  assign done    = (req && (state == S_ON)) || (!req && (state == S_OFF));

endmodule

// File: tb/tb_power_gate_seq_multi.sv
// Self-checking bench for power_gate_seq_multi: directed sequences plus a
// randomized run compared against a behavioural model of the sequencer.
module tb_power_gate_seq_multi;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int LW = $clog2(N + 1);

  localparam int M_IDLE = 0;
  localparam int M_RISE = 1;
  localparam int M_FULL = 2;
  localparam int M_ISO  = 3;
  localparam int M_FALL = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           power;
  logic           external_pg;
  logic [N*W-1:0] hold_time;
  logic           wu_bypass_mux;
  logic           isolate_byp;
  logic [N-1:0]   rail;
  logic [LW-1:0]  level;
  logic           isolate;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;

  int m_lvl  = 0;
  int m_cnt  = 0;
  int m_mode = M_IDLE;
  bit m_iso  = 1'b1;

  power_gate_seq_multi #(.N_STEPS(N), .CNT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .power        (power),
    .external_pg  (external_pg),
    .hold_time    (hold_time),
    .wu_bypass_mux(wu_bypass_mux),
    .isolate_byp  (isolate_byp),
    .rail         (rail),
    .level        (level),
    .isolate      (isolate),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  function automatic int dwell(input int k);
    int d;
    d = int'(hold_time[k*W +: W]);
    return (d == 0) ? 1 : d;
  endfunction

  // Reference behaviour: advance the model by one clock edge using the current inputs.
  task automatic model_step();
    bit req;
    int wrap;
    req  = power | external_pg;
    wrap = 1 << W;
    if (rst) begin
      m_lvl  = 0;
      m_cnt  = 0;
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_cnt = 0;
          if (req) begin
            m_mode = M_RISE;
            m_lvl  = 1;
          end else begin
            m_lvl = 0;
          end
        end
        M_RISE: begin
          if (!req) begin
            m_mode = M_FALL;
            m_cnt  = 0;
          end else if (m_cnt == dwell(m_lvl - 1) - 1) begin
            m_cnt = 0;
            if (m_lvl == N) m_mode = M_FULL;
            else            m_lvl  = m_lvl + 1;
          end else begin
            m_cnt = (m_cnt + 1) % wrap;
          end
        end
        M_FULL: if (!req) m_mode = M_ISO;
        M_ISO: begin
          if (req) m_mode = M_FULL;
          else begin
            m_mode = M_FALL;
            m_cnt  = 0;
          end
        end
        default: begin
          if (req) begin
            m_mode = M_RISE;
            m_cnt  = 0;
          end else if (m_cnt == dwell(m_lvl - 1) - 1) begin
            m_lvl = m_lvl - 1;
            m_cnt = 0;
            if (m_lvl == 0) m_mode = M_IDLE;
          end else begin
            m_cnt = (m_cnt + 1) % wrap;
          end
        end
      endcase
    end
    m_iso = (m_mode != M_FULL);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit req;
    bit exp_busy;
    bit exp_done;
    req      = power | external_pg;
    exp_busy = (m_mode == M_RISE) || (m_mode == M_ISO) || (m_mode == M_FALL);
    exp_done = (req && m_mode == M_FULL) || (!req && m_mode == M_IDLE);
    check("model_rail", rail, (1 << m_lvl) - 1);
    check("model_level", level, m_lvl);
    check("model_isolate", isolate, wu_bypass_mux ? isolate_byp : m_iso);
    check("model_busy", busy, exp_busy);
    check("model_done", done, exp_done);
  endtask

  task automatic applyStimulus(input bit r, input bit p, input bit e);
    rst         = r;
    power       = p;
    external_pg = e;
    model_step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst           = 1'b1;
    power         = 1'b0;
    external_pg   = 1'b0;
    wu_bypass_mux = 1'b0;
    isolate_byp   = 1'b0;
    hold_time     = {N{4'd2}};

    // Reset state
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    check("reset_rail", rail, 0);
    check("reset_level", level, 0);
    check("reset_isolate", isolate, 1);
    check("reset_done", done, 1);
    check("reset_busy", busy, 0);

    // Full power-up with dwell 2 on every step
    for (int k = 0; k <= 8; k++) begin
      applyStimulus(0, 1, 0);
      if (k == 0) check("up_rail_e0", rail, 4'b0001);
      if (k == 2) check("up_rail_e2", rail, 4'b0011);
      if (k == 4) check("up_rail_e4", rail, 4'b0111);
      if (k == 6) check("up_rail_e6", rail, 4'b1111);
      if (k == 7) begin
        check("up_done_e7", done, 0);
        check("up_iso_e7", isolate, 1);
      end
      if (k == 8) begin
        check("on_done", done, 1);
        check("on_isolate", isolate, 0);
        check("on_busy", busy, 0);
      end
    end

    // Power-down from ON
    for (int j = 0; j <= 9; j++) begin
      applyStimulus(0, 0, 0);
      if (j == 0) begin
        check("iso_isolate", isolate, 1);
        check("iso_busy", busy, 1);
      end
      if (j == 3) check("dn_rail_t3", rail, 4'b0111);
      if (j == 5) check("dn_rail_t5", rail, 4'b0011);
      if (j == 7) check("dn_rail_t7", rail, 4'b0001);
      if (j == 8) check("dn_done_t8", done, 0);
      if (j == 9) begin
        check("dn_rail_t9", rail, 4'b0000);
        check("dn_done_t9", done, 1);
        check("dn_busy_t9", busy, 0);
      end
    end

    // Abort during power-up at level 2
    for (int k = 0; k <= 8; k++) begin
      applyStimulus(0, k < 3, 0);
      check("abort_isolate", isolate, 1);
      if (k == 3) begin
        check("abort_busy", busy, 1);
        check("abort_rail_e3", rail, 4'b0011);
      end
      if (k == 5) check("abort_rail_e5", rail, 4'b0001);
      if (k == 7) begin
        check("abort_rail_e7", rail, 4'b0000);
        check("abort_done_e7", done, 1);
      end
    end

    // Zero dwell on step 1 behaves as one cycle
    hold_time = {4'd3, 4'd3, 4'd0, 4'd3};
    for (int k = 0; k <= 10; k++) begin
      applyStimulus(0, 1, 0);
      if (k == 3)  check("zero_rail_e3", rail, 4'b0011);
      if (k == 4)  check("zero_rail_e4", rail, 4'b0111);
      if (k == 9)  check("zero_done_e9", done, 0);
      if (k == 10) begin
        check("zero_done_e10", done, 1);
        check("zero_rail_e10", rail, 4'b1111);
      end
    end
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0);
    check("zero_off_rail", rail, 0);
    check("zero_off_done", done, 1);

    // Re-request while in ISO returns straight to ON
    hold_time = {N{4'd2}};
    for (int k = 0; k <= 8; k++) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    check("reiso_busy", busy, 1);
    check("reiso_rail", rail, 4'b1111);
    applyStimulus(0, 1, 0);
    check("reon_rail", rail, 4'b1111);
    check("reon_isolate", isolate, 0);
    check("reon_done", done, 1);
    check("reon_busy", busy, 0);

    // External request alone starts the sequence
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    check("ext_rail", rail, 4'b0001);
    check("ext_busy", busy, 1);
    applyStimulus(1, 0, 0);

    // Reset mid power-up drops every rail in one edge; then bypass isolation
    for (int k = 0; k <= 6; k++) begin
      applyStimulus(k == 6, 1, 0);
      if (k == 5) check("rstmid_rail_e5", rail, 4'b0111);
      if (k == 6) begin
        check("rstmid_rail", rail, 0);
        check("rstmid_level", level, 0);
        check("rstmid_isolate", isolate, 1);
      end
    end
    wu_bypass_mux = 1'b1;
    isolate_byp   = 1'b0;
    #1;
    check("byp_isolate_0", isolate, 0);
    isolate_byp = 1'b1;
    #1;
    check("byp_isolate_1", isolate, 1);
    wu_bypass_mux = 1'b0;
    applyStimulus(1, 0, 0);

    // Randomized run against the model
    begin
      bit p = 1'b0;
      bit e = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 39) == 0) p = ~p;
        if ($urandom_range(0, 59) == 0) e = ~e;
        if ($urandom_range(0, 49) == 0) begin
          for (int s = 0; s < N; s++) hold_time[s*W +: W] = 4'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 9) == 0) begin
          wu_bypass_mux = 1'($urandom_range(0, 1));
          isolate_byp   = 1'($urandom_range(0, 1));
        end
        applyStimulus($urandom_range(0, 199) == 0, p, e);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/power_gate_seq_multi.md
POWER_GATE_SEQ_MULTI -- requirements
Module: power_gate_seq_multi

Interface
REQ-001 Parameter N_STEPS, default 8, number of sequenced rails (2..32).
REQ-002 Parameter CNT_W, default 8, dwell-counter width per step.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 power  input  1  software power request.
REQ-006 external_pg  input  1  external power request; req = power | external_pg.
REQ-007 hold_time  input  N_STEPS*CNT_W  per-step dwell cycles; step k at bits [k*CNT_W +: CNT_W].
REQ-008 wu_bypass_mux  input  1  selects bypass isolation source.
REQ-009 isolate_byp  input  1  bypass isolation value.
REQ-010 rail  output  N_STEPS  registered rail enables, thermometer-coded.
REQ-011 level  output  $clog2(N_STEPS+1)  number of rails currently enabled (L).
REQ-012 isolate  output  1  domain isolation, active-high.
REQ-013 busy  output  1  high in UP, ISO or DOWN.
REQ-014 done  output  1  request satisfied.

Function
REQ-015 States SHALL be OFF, UP, ON, ISO, DOWN; rail[k] SHALL equal (k < L) for all k.
REQ-016 Dwell D(k) SHALL be hold_time step k, with 0 treated as 1; hold_time SHALL be sampled live each cycle.
REQ-017 OFF: when req=1, next state UP with L=1, cnt=0; otherwise hold, L=0.
REQ-018 UP, req=0: next state DOWN, L and cnt=0 unchanged/cleared respectively (abort, reverse from current L).
REQ-019 UP, req=1, cnt==D(L-1)-1: if L==N_STEPS next state ON, else L=L+1; cnt=0 in both cases.
REQ-020 UP, req=1, otherwise: cnt=cnt+1.
REQ-021 ON: req=0 gives next state ISO; otherwise hold.
REQ-022 ISO: one cycle; req=1 returns to ON, req=0 goes to DOWN with cnt=0; L stays N_STEPS.
REQ-023 DOWN, req=1: next state UP, L unchanged, cnt=0.
REQ-024 DOWN, req=0, cnt==D(L-1)-1: L=L-1, cnt=0; if new L==0 the next state SHALL be OFF.
REQ-025 DOWN, otherwise: cnt=cnt+1.
REQ-026 Internal isolation register SHALL load 0 exactly when the next state is ON, else 1, so isolate falls in the first ON cycle and rises in the ISO cycle.
REQ-027 isolate SHALL be isolate_byp when wu_bypass_mux=1, else the internal register; this path is combinational.
REQ-028 done SHALL be (req & state==ON) | (~req & state==OFF), combinational.
REQ-029 Unreachable state encodings SHALL go to OFF with L=0 on the next edge.

Reset
REQ-030 While rst=1 at an edge: state OFF, L=0, cnt=0, rail all 0, internal isolation 1, regardless of current state.
REQ-031 Reset mid-sequence SHALL drop all rails in one edge; no reverse sequencing.
REQ-032 After reset with req=0, done=1 and busy=0.

Verification (N_STEPS=4, hold_time all 2 unless stated)
REQ-033 power=1 sampled at cycle 0 -> rail=0001@1, 0011@3, 0111@5, 1111@7; state ON, isolate=0, done=1 @9.
REQ-034 From ON, power=0 sampled at t -> isolate=1 @t+1; rail=0111@t+4, 0011@t+6, 0001@t+8, 0000 and state OFF, done=1 @t+10.
REQ-035 Power-up, drop power at cycle 3 (L=2) -> DOWN; rail=0001@6, 0000 and OFF @8; isolate stays 1 throughout.
REQ-036 hold_time step 1 = 0, others 3 -> step 1 dwell is 1 cycle; ON reached @11.
REQ-037 In ISO, reassert power -> ON next cycle, rail stays 1111, isolate=0.
REQ-038 rst=1 at cycle 6 of power-up -> rail=0000, level=0, isolate=1 next edge; wu_bypass_mux=1, isolate_byp=0 -> isolate=0 immediately.
